// File: rtl/result_writeback.sv
// Result writeback stage: captures the NxN accumulator tile from the systolic array,
// requantizes each element (round, optional ReLU, saturate) and writes the tile back
// to the unified buffer one row word per granted cycle.
module result_writeback #(
    parameter int unsigned N            = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned BUFFER_WIDTH = N * DATA_WIDTH,
    parameter int unsigned SHIFT_W      = $clog2(ACC_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [SHIFT_W-1:0]            shift,
    input  logic                          relu_en,
    input  logic [N*N*ACC_WIDTH-1:0]      results_flat,
    input  logic                          result_valid,
    input  logic                          wr_grant,
    output logic                          wr_req,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [BUFFER_WIDTH-1:0]       wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);

    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

    // Saturation bounds expressed in the widened (ACC_WIDTH+1) requant domain
    localparam logic signed [ACC_WIDTH:0] SatMax = (ACC_WIDTH + 1)'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {StIdle, StArmed, StWrite, StDone} state_e;

    state_e                                  state_q, state_d;
    logic [RowW-1:0]                         row_q, row_d;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]      tile_q, tile_d;
    logic [ADDR_WIDTH-1:0]                   base_q, base_d;
    logic [SHIFT_W-1:0]                      shift_q, shift_d;
    logic                                    relu_q, relu_d;
    logic                                    sat_q, sat_d;

    logic [BUFFER_WIDTH-1:0]                 row_word;
    logic                                    row_sat;

    // Requantize the currently addressed row of the captured tile
    always_comb begin
        logic signed [ACC_WIDTH:0] y;
        logic signed [ACC_WIDTH:0] rnd;
        row_word = '0;
        row_sat  = 1'b0;
        for (int c = 0; c < int'(N); c++) begin
            y   = {tile_q[row_q][c][ACC_WIDTH-1], tile_q[row_q][c]};
            rnd = '0;
            if (shift_q != '0) begin
                // Extra headroom bit keeps the rounding add from wrapping
                rnd = (ACC_WIDTH + 1)'(1) << (shift_q - 1'b1);
                y   = (y + rnd) >>> shift_q;
            end
            if (relu_q && (y < 0)) begin
                y = '0;
            end
            if (y > SatMax) begin
                y       = SatMax;
                row_sat = 1'b1;
            end else if (y < SatMin) begin
                y       = SatMin;
                row_sat = 1'b1;
            end
            row_word[c*DATA_WIDTH +: DATA_WIDTH] = y[DATA_WIDTH-1:0];
        end
    end

    // Write-port outputs; address and data are forced to zero outside a write strobe
    always_comb begin
        wr_req   = (state_q == StWrite);
        wr_en    = wr_req & wr_grant;
        wr_addr  = wr_en ? base_q + ADDR_WIDTH'(row_q) : '0;
        wr_data  = wr_en ? row_word : '0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        sat_flag = sat_q;
    end

    // Next-state logic: job sequencing, config latch, tile capture, row stepping
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tile_d  = tile_q;
        base_d  = base_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StArmed;
                    base_d  = base_addr;
                    shift_d = shift;
                    relu_d  = relu_en;
                    sat_d   = 1'b0;
                end
            end
            StArmed: begin
                if (result_valid) begin
                    tile_d  = results_flat;
                    row_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wr_en) begin
                    row_d = row_q + 1'b1;
                    if (row_sat) begin
                        sat_d = 1'b1;
                    end
                    if (row_q == RowW'(N - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            tile_q  <= '0;
            base_q  <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tile_q  <= tile_d;
            base_q  <= base_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: directed and randomized jobs compared
// against an arithmetic requantization model.
module tb_result_writeback;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int ADW = 8;
    localparam int BW = 32;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADW-1:0]    base_addr;
    logic [SW-1:0]     shift;
    logic              relu_en;
    logic [N*N*AW-1:0] results_flat;
    logic              result_valid;
    logic              wr_grant;
    logic              wr_req;
    logic              wr_en;
    logic [ADW-1:0]    wr_addr;
    logic [BW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic              sat_flag;

    int checks = 0;
    int passes = 0;
    int tile_m[16];

    result_writeback #(
        .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .BUFFER_WIDTH(BW), .SHIFT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
        .shift(shift), .relu_en(relu_en), .results_flat(results_flat),
        .result_valid(result_valid), .wr_grant(wr_grant), .wr_req(wr_req), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Round-half-up via floor division, then ReLU, then clamp to the signed 8-bit range
    function automatic int ref_q(input longint x, input int sh, input bit rl, output bit sat);
        longint y, d, num;
        y = x;
        if (sh > 0) begin
            d   = longint'(1) << sh;
            num = x + d / 2;
            y   = num / d;
            if ((num % d) != 0 && num < 0) y = y - 1;
        end
        if (rl && y < 0) y = 0;
        sat = 1'b0;
        if (y > 127) begin
            y = 127; sat = 1'b1;
        end else if (y < -128) begin
            y = -128; sat = 1'b1;
        end
        return int'(y);
    endfunction

    task automatic pack_tile();
        for (int i = 0; i < 16; i++) results_flat[i*AW +: AW] = tile_m[i];
    endtask

    task automatic rand_tile();
        for (int i = 0; i < 16; i++) tile_m[i] = int'($urandom) >>> $urandom_range(0, 30);
    endtask

    // One full job; gmode 0: grant always, 1: grant 1,0,0 repeating, 2: random grant
    task automatic run_job(input logic [7:0] base, input int sh, input bit rl, input int gmode,
                           input string tag);
        logic [31:0] exp_w[4];
        bit          exp_sat;
        bit          s;
        int          q;
        int          writes;
        int          last_wr;
        bit          done_seen;
        logic        g;
        logic [7:0]  ea;
        exp_sat = 1'b0;
        for (int r = 0; r < 4; r++) begin
            exp_w[r] = '0;
            for (int c = 0; c < 4; c++) begin
                q = ref_q(longint'(tile_m[r*4+c]), sh, rl, s);
                exp_w[r][c*8 +: 8] = q[7:0];
                exp_sat |= s;
            end
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; shift = SW'(sh); relu_en = rl; wr_grant = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_armed_busy"}, busy, 1);
        check({tag, "_sat_cleared"}, sat_flag, 0);
        pack_tile();
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        writes = 0; last_wr = 0; done_seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
            if (cyc > 1) @(negedge clk);
            case (gmode)
                0:       g = 1'b1;
                1:       g = ((cyc - 1) % 3 == 0);
                default: g = 1'($urandom_range(0, 1));
            endcase
            wr_grant = g;
            // Late tile and start must both be ignored while writing
            result_valid = (cyc == 2);
            if (cyc == 2) results_flat = {16{$urandom}};
            start = (cyc == 3);
            base_addr = (cyc == 3) ? 8'h55 : base;
            #1;
            check({tag, "_wr_en"}, wr_en, (writes < 4) ? g : 1'b0);
            if (wr_en) begin
                ea = base + 8'(writes);
                check({tag, "_addr"}, wr_addr, ea);
                if (writes < 4) check({tag, "_data"}, wr_data, exp_w[writes]);
                writes++;
                last_wr = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                check({tag, "_done_writes"}, writes, 4);
                check({tag, "_done_timing"}, cyc, last_wr + 1);
                if (gmode == 0) check({tag, "_latency"}, cyc, 5);
                check({tag, "_sat_flag"}, sat_flag, exp_sat);
            end
        end
        start = 1'b0; result_valid = 1'b0; base_addr = base;
        if (!done_seen) check({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
        wr_grant = 1'b0;
        #1;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int writes;
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; shift = '0; relu_en = 1'b0;
        results_flat = '0; result_valid = 1'b0; wr_grant = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_sat", sat_flag, 0);
        @(negedge clk);
        rst = 1'b0;

        // Identity tile, no shift
        for (int i = 0; i < 16; i++) tile_m[i] = i;
        run_job(8'h10, 0, 1'b0, 0, "ident");

        // Rounding cases, without and with ReLU
        rand_tile();
        for (int i = 4; i < 16; i++) tile_m[i] = tile_m[i] % 2000;
        tile_m[0] = 24; tile_m[1] = -24; tile_m[2] = 23; tile_m[3] = -23;
        tile_m[4] = 8;  tile_m[5] = -8;
        run_job(8'h20, 4, 1'b0, 0, "round");
        run_job(8'h20, 4, 1'b1, 0, "round_relu");

        // Saturation, then a clean job must see sat_flag cleared
        for (int i = 0; i < 16; i++) tile_m[i] = i - 8;
        tile_m[5] = 1000; tile_m[10] = -1000;
        run_job(8'h30, 0, 1'b0, 0, "sat");
        for (int i = 0; i < 16; i++) tile_m[i] = i * 3 - 20;
        run_job(8'hFE, 0, 1'b0, 1, "wrap_stall");

        // Tile offered while idle is dropped
        @(negedge clk);
        results_flat = {16{$urandom}}; result_valid = 1'b1; wr_grant = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("idle_valid_wr_req", wr_req, 0);
            check("idle_valid_busy", busy, 0);
            @(negedge clk);
        end

        // start and abort together: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check("start_abort_busy", busy, 0);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            rand_tile();
            run_job(8'($urandom), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 2, "rand");
        end

        // Abort after two rows
        rand_tile();
        @(negedge clk);
        start = 1'b1; base_addr = 8'h40; shift = 5'd2; relu_en = 1'b0; wr_grant = 1'b1;
        @(negedge clk);
        start = 1'b0; pack_tile(); result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        writes = 0;
        for (int cyc = 0; cyc < 10 && writes < 2; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (wr_en) writes++;
        end
        check("abort_two_rows", writes, 2);
        @(negedge clk);
        abort = 1'b1; wr_grant = 1'b0;
        @(negedge clk);
        abort = 1'b0; wr_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("abort_busy", busy, 0);
            check("abort_wr_en", wr_en, 0);
            check("abort_wr_req", wr_req, 0);
            check("abort_done", done, 0);
            @(negedge clk);
        end

        // Reset in the middle of a job
        rand_tile();
        start = 1'b1; base_addr = 8'h50;
        @(negedge clk);
        start = 1'b0; pack_tile(); result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        #1;
        check("rst_mid_wr_en", wr_en, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wr_en_after", wr_en, 0);
        check("rst_mid_wr_req", wr_req, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_sat", sat_flag, 0);
        rst = 1'b0;

        // Normal operation resumes after reset
        rand_tile();
        run_job(8'h60, 3, 1'b1, 0, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
